// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

  // Responder sequencing: zero-fill, wait for request, wait states, respond.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dm_state_e;

  // Wait-state counter width; WAIT_CYCLES must fit (0..15).
  localparam int unsigned WAIT_CNT_W = 4;

  // Replace the lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [31:0] dm_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port word RAM: per-lane write enable, registered read-first output.
module dm_ram #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read returns the pre-write word; enabled lanes are updated on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: self zero-fill, wait states, one response per request.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  dm_state_e             state_q, state_d;
  logic [AW-1:0]         fill_q, fill_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  err_q, err_d;
  logic [31:0]           hold_q, hold_d;
  logic                  done_q, done_d;

  logic                  acc_write;
  logic [31:0]           acc_addr, acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_err, acc_fire;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [AW-1:0]         ram_addr;
  logic [31:0]           ram_wdata, ram_rdata;
  logic [31:0]           resp_word;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request; otherwise it uses the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) ||
              ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Response word: zero on error, merged word for stores, raw word for loads.
  always_comb begin
    if (err_q)     resp_word = '0;
    else if (wr_q) resp_word = dm_merge(ram_rdata, wdata_q, be_q);
    else           resp_word = ram_rdata;
  end

  // Next-state logic for the FSM, fill pointer, wait counter and latches.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    err_d    = err_q;
    hold_d   = hold_q;
    done_d   = done_q;
    acc_fire = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_d = fill_q + AW'(1);
        if (fill_q == LAST_WORD) begin
          fill_d  = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            acc_fire = 1'b1;
            state_d  = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q == WAIT_CNT_W'(1)) begin
          acc_fire = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        hold_d  = resp_word;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    if (acc_fire) err_d = acc_err;
  end

  // RAM port shared between the zero-fill and request accesses.
  always_comb begin
    if (state_q == ST_INIT) begin
      ram_en    = 1'b1;
      ram_we    = '1;
      ram_addr  = fill_q;
      ram_wdata = '0;
    end else begin
      ram_en    = acc_fire && !acc_err;
      ram_we    = acc_write ? acc_be : '0;
      ram_addr  = acc_addr[AW+1:2];
      ram_wdata = acc_wdata;
    end
  end

  // State registers; reset drops any in-flight request and restarts the fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      fill_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  dm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM data is only valid in RESP; the held copy covers the other states.
  assign resp_rdata = (state_q == ST_RESP) ? resp_word : hold_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign init_done  = done_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder (DEPTH_WORDS=8; WAIT_CYCLES 1, 0 and 3).
module tb_dm_responder;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance, WAIT_CYCLES=1
  logic        a_valid, a_ready, a_write, a_rvalid, a_rerr, a_done;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;

  // Streaming instances, WAIT_CYCLES=0 and 3, sharing one request source
  logic        s_valid, s_write;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s0_ready, s0_rvalid, s0_rerr, s0_done;
  logic        s1_ready, s1_rvalid, s1_rerr, s1_done;
  logic [31:0] s0_rdata, s1_rdata;

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_rerr),
    .init_done(a_done)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(s_valid), .req_ready(s0_ready), .req_write(s_write),
    .req_addr(s_addr), .req_wdata(s_wdata), .req_be(s_be),
    .resp_valid(s0_rvalid), .resp_rdata(s0_rdata), .resp_err(s0_rerr),
    .init_done(s0_done)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(reset),
    .req_valid(s_valid), .req_ready(s1_ready), .req_write(s_write),
    .req_addr(s_addr), .req_wdata(s_wdata), .req_be(s_be),
    .resp_valid(s1_rvalid), .resp_rdata(s1_rdata), .resp_err(s1_rerr),
    .init_done(s1_done)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  vec_t vecs [17];
  exp_t exp_q [$];
  int   n_resp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the main instance: pop and compare on each response.
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with none pending", a_rdata, a_rerr);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", a_rdata, e.rd);
        chk("resp_err", 32'(a_rerr), 32'(e.err));
        chk("resp_latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  // Streaming instances: accept spacing and response latency.
  int s_last [2];
  int s_nacc [2];
  int s_nresp [2];

  task automatic stream_mon(input int i, input logic rdy, input logic rv,
                            input logic [31:0] rd, input logic er);
    int w;
    w = (i == 0) ? 0 : 3;
    if (s_valid && rdy) begin
      if (s_nacc[i] > 0) chk($sformatf("w%0d_accept_spacing", w), 32'(cyc - s_last[i]), 32'(w + 2));
      s_last[i] = cyc;
      s_nacc[i]++;
    end
    if (rv) begin
      chk($sformatf("w%0d_latency", w), 32'(cyc - s_last[i]), 32'(w + 1));
      chk($sformatf("w%0d_rdata", w), rd, 32'd0);
      chk($sformatf("w%0d_err", w), 32'(er), 32'd0);
      s_nresp[i]++;
    end
  endtask

  always @(negedge clk) begin
    stream_mon(0, s0_ready, s0_rvalid, s0_rdata, s0_rerr);
    stream_mon(1, s1_ready, s1_rvalid, s1_rdata, s1_rerr);
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
    int   t;
    exp_t e;
    t = 0;
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
    @(negedge clk);
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h", addr);
    end else begin
      e.rd = exp_rd; e.err = exp_err; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: %0d responses still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at the negedge where reset is released.
  task automatic check_init();
    int high;
    high = 0;
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b0 || a_done !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) high++;
    end
    chk("init_ready_low_cycles", 32'(high), 32'd0);
    @(negedge clk);
    chk("init_ready_high", 32'(a_ready), 32'd1);
    chk("init_done_high", 32'(a_done), 32'd1);
    chk("init_ready_w0_w3", 32'({s0_ready, s1_ready}), 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h00001122, 4'h3, 32'hDEAD1122, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEAD1122, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h1C,       32'h0,        4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h1C,       32'hA5A5A5A5, 4'h8, 32'hA5000000, 1'b0};
    vecs[9]  = '{1'b1, 32'h1C,       32'h12345678, 4'h0, 32'hA5000000, 1'b0};
    vecs[10] = '{1'b0, 32'h1C,       32'h0,        4'hF, 32'hA5000000, 1'b0};
    vecs[11] = '{1'b1, 32'h0,        32'hCAFEF00D, 4'h5, 32'h00FE000D, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        32'h0,        4'hF, 32'h00FE000D, 1'b0};
    vecs[13] = '{1'b0, 32'h40000000, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h3,        32'h77777777, 4'hF, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 32'h4,        32'h11223344, 4'hF, 32'h11223344, 1'b0};
    vecs[16] = '{1'b0, 32'h4,        32'hFFFFFFFF, 4'h0, 32'h11223344, 1'b0};

    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    s_valid = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
    for (int i = 0; i < 2; i++) begin
      s_last[i] = 0; s_nacc[i] = 0; s_nresp[i] = 0;
    end

    // Reset values
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(a_ready), 32'd0);
    chk("rst_resp_valid", 32'(a_rvalid), 32'd0);
    chk("rst_resp_rdata", a_rdata, 32'd0);
    chk("rst_resp_err", 32'(a_rerr), 32'd0);
    chk("rst_init_done", 32'(a_done), 32'd0);
    reset = 1'b1;
    check_init();

    // Table-driven requests, one at a time
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1 issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd, vecs[i].exp_err);
      wait_drain();
      @(negedge clk);
      chk("hold_rdata", a_rdata, vecs[i].exp_rd);
      chk("hold_err", 32'(a_rerr), 32'(vecs[i].exp_err));
    end

    // Back-to-back loads with req_valid held high, WAIT_CYCLES=0 and 3
    @(posedge clk);
    #1;
    s_valid = 1'b1; s_write = 1'b0; s_addr = 32'h1C; s_be = 4'hF;
    t = 0;
    while ((s_nresp[0] < 4 || s_nresp[1] < 4) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("stream_resp_count", 32'(s_nresp[0] >= 4 && s_nresp[1] >= 4), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Reset while a store to 0x4 sits in WAIT
    @(posedge clk);
    #1;
    snap = n_resp;
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h4; a_wdata = 32'h55667788; a_be = 4'hF;
    t = 0;
    @(negedge clk);
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drop_accept_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    chk("drop_in_wait", 32'(a_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("drop_resp_valid", 32'(a_rvalid), 32'd0);
    chk("drop_init_done", 32'(a_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_init();
    chk("drop_no_response", 32'(n_resp), 32'(snap));

    // Refill cleared earlier contents; the dropped store never landed
    @(posedge clk);
    #1 issue(1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_drain();
    @(posedge clk);
    #1 issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the multi-cycle CPU variant. It is the memory end of the load/store interface: the CPU core drives requests, and this block accepts them, applies a configurable number of wait states, commits byte-enabled writes or reads a word, and returns exactly one response per request. After reset it zero-fills its storage by itself, so the core can never observe stale contents.

## Interface
- `DEPTH_WORDS`, 3072: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `WAIT_CYCLES`, 1: wait states between accept and memory access; legal range 0..15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_be` in 4: byte enables; bit i selects byte lane i (little-endian lanes).
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 32: word read, or post-write merged word for a store.
- `resp_err` out 1: request was misaligned or out of range.
- `init_done` out 1: zero-fill has finished.

## Operation
- States are INIT, IDLE, WAIT and RESP.
- **INIT** (entered on reset):
  - Writes zero to word k on each cycle, for k = 0 .. DEPTH_WORDS-1.
  - Moves to IDLE after the last word; `init_done` rises with that transition and stays high until the next reset.
- **IDLE**:
  - `req_ready`=1.
  - A request is accepted when `req_valid`&&`req_ready` is true at a rising edge. The block latches write, addr, wdata and be at that edge.
  - Moves to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
- **WAIT**:
  - `req_ready`=0.
  - The counter decrements each cycle. On the edge where it reaches 0 the memory access is performed and the state moves to RESP.
- **Memory access at the entering-RESP edge**:
  - Error check: `resp_err` is set if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. On error there is no memory access and `resp_rdata`=0.
  - Store: only lanes with be[i]=1 are overwritten. `resp_rdata` is the resulting word. be=4'b0000 is a legal no-op store and returns the unchanged word.
  - Load: the full word is returned; be is ignored.
- **RESP**:
  - `resp_valid`=1 for exactly this one cycle, with `resp_rdata` and `resp_err` valid.
  - There is no response backpressure.
  - Returns to IDLE on the next edge.
- Only one request is outstanding at any time. `req_*` inputs are ignored while `req_ready`=0.
- `resp_rdata` and `resp_err` hold their last values outside RESP. Only `resp_valid` qualifies them.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `init_done`=0. After reset the state is INIT with fill pointer 0.
- Reset asserted mid-operation (INIT, WAIT or RESP):
  - The in-flight request is dropped, with no response and no write.
  - The block restarts INIT from word 0.
- INIT length is exactly DEPTH_WORDS cycles after reset deasserts. `req_ready` first goes high in cycle DEPTH_WORDS.
- Latency: if the accept edge ends cycle 0, `resp_valid` is high in cycle WAIT_CYCLES+1.
- `req_ready` returns high in cycle WAIT_CYCLES+2.
- Peak throughput is one request per WAIT_CYCLES+2 cycles.
- A load issued after a store to the same word returns the merged data. There is no hazard because accesses are serialized.
- Address boundaries:
  - Word DEPTH_WORDS-1 is valid.
  - Word DEPTH_WORDS gives an error.
  - Addresses are never wrapped or truncated.

## Structure
- Package `dm_pkg` holds:
  - the state enum (INIT, IDLE, WAIT, RESP);
  - a 4-bit wait-counter width constant;
  - a byte-merge function (old, new, be) -> word.
- Sub-module `dm_ram` is a synchronous single-port word RAM with per-lane write enable and registered read.
  - It is used both for the INIT fill and for request accesses.
  - The INIT fill drives all four lanes with data 0.
- FSM, counter, request latches and the error check live in `dm_responder`.

## Test plan
1. Reset then idle, with DEPTH_WORDS=8 and WAIT_CYCLES=1 → `req_ready` low for 8 cycles, then high with `init_done`=1. All outputs read 0 during reset.
2. Store addr 0x10, data 0xDEADBEEF, be 4'b1111; then load 0x10 → both responses arrive 2 cycles after accept. The load returns 0xDEADBEEF with err=0.
3. Store addr 0x10, data 0x00001122, be 4'b0011, over 0xDEADBEEF → `resp_rdata`=0xDEAD1122. A following load returns 0xDEAD1122.
4. Load 0x12 (misaligned) and load 4*DEPTH_WORDS → `resp_err`=1 and `resp_rdata`=0 for both. A store to 4*DEPTH_WORDS leaves memory unchanged.
5. WAIT_CYCLES=0 and WAIT_CYCLES=3 with back-to-back `req_valid` held high → `resp_valid` arrives 1 and 4 cycles after accept, with accepts spaced 2 and 5 cycles apart.
6. Assert reset during WAIT of a store to 0x4 → no response is produced, INIT re-runs, and a later load of 0x4 returns 0.
